seq_scan_ctrl: RTL

Serial-pattern scan controller. It accepts parallel words over a valid/ready handshake and sequences them MSB-first, one bit per clock, through a programmable overlapping pattern matcher. It emits a per-bit hit strobe and, at the end of each word, a saturating match count over a result handshake. It sits between a word producer and downstream logic that needs per-word pattern statistics, and is the sequencing and configuration front end for the serial detector datapath.

---
 rtl/seq_scan_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/seq_scan_ctrl.sv
// Serial pattern scan controller: shifts words MSB-first through an overlapping matcher.
// Optional macro SEQ_SCAN_CROSS_WORD_EN keeps match history across word boundaries.
module seq_scan_ctrl #(
  parameter int WORD_W = 8,
  parameter int PAT_W  = 4,
  parameter int LEN_W  = 3,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pat,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              ser_x,
  output logic              ser_vld,
  output logic              hit,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count
);

  localparam int BC_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t              r_state, w_state_nx;
  logic [WORD_W-1:0]   r_shreg;
  logic [BC_W-1:0]     r_bcnt;
  logic [PAT_W-1:0]    r_hist, r_pat;
  logic [LEN_W-1:0]    r_hcnt, r_len;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ser_x, r_ser_vld, r_hit, r_res_valid;

  logic [LEN_W-1:0]    w_len_n;
  logic                w_last, w_bit, w_hit_nx;
  logic [PAT_W-1:0]    w_hist_nx, w_mask;
  logic [LEN_W:0]      w_hcnt_p1;
  logic [LEN_W-1:0]    w_hcnt_nx;
  logic [CNT_W-1:0]    w_cnt_nx;

  always_comb begin
    w_len_n = cfg_len;
    if (cfg_len == '0)                    w_len_n = LEN_W'(1);
    else if (cfg_len > LEN_W'(PAT_W))     w_len_n = LEN_W'(PAT_W);
  end

  assign w_last    = (r_bcnt == BC_W'(WORD_W - 1));
  assign w_bit     = r_shreg[WORD_W-1];
  assign w_hist_nx = {r_hist[PAT_W-2:0], w_bit};
  assign w_hcnt_p1 = {1'b0, r_hcnt} + {{LEN_W{1'b0}}, 1'b1};
  assign w_hcnt_nx = (r_hcnt == LEN_W'(PAT_W)) ? r_hcnt : w_hcnt_p1[LEN_W-1:0];

  // Only the low r_len history bits take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_W; i++) w_mask[i] = (i < int'(r_len));
  end

  assign w_hit_nx = (w_hcnt_p1 >= {1'b0, r_len}) &&
                    (((w_hist_nx ^ r_pat) & w_mask) == '0);
  assign w_cnt_nx = (w_hit_nx && (r_cnt != '1)) ? r_cnt + CNT_W'(1) : r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nx = S_SHIFT;
      S_SHIFT: if (w_last)    w_state_nx = S_DONE;
      S_DONE:  if (res_ready) w_state_nx = S_IDLE;
      default:                w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg     <= '0;
      r_bcnt      <= '0;
      r_hist      <= '0;
      r_hcnt      <= '0;
      r_cnt       <= '0;
      r_pat       <= PAT_W'(3'b101);
      r_len       <= LEN_W'(3);
      r_ser_x     <= 1'b0;
      r_ser_vld   <= 1'b0;
      r_hit       <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_ser_vld <= 1'b0;
      r_hit     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_we) begin
            r_pat <= cfg_pat;
            r_len <= w_len_n;
          end
          if (in_valid) begin
            r_shreg <= in_data;
            r_bcnt  <= '0;
            r_cnt   <= '0;
`ifdef SEQ_SCAN_CROSS_WORD_EN
`else
            r_hist  <= '0;
            r_hcnt  <= '0;
`endif
          end
        end
        S_SHIFT: begin
          r_shreg   <= r_shreg << 1;
          r_hist    <= w_hist_nx;
          r_hcnt    <= w_hcnt_nx;
          r_bcnt    <= r_bcnt + BC_W'(1);
          r_ser_x   <= w_bit;
          r_ser_vld <= 1'b1;
          r_hit     <= w_hit_nx;
          r_cnt     <= w_cnt_nx;
          if (w_last) r_res_valid <= 1'b1;
        end
        S_DONE: if (res_ready) r_res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign ser_x     = r_ser_x;
  assign ser_vld   = r_ser_vld;
  assign hit       = r_hit;
  assign res_valid = r_res_valid;
  assign res_count = r_cnt;

endmodule
